// File: rtl/led_pwm_fader.sv
// led_pwm_fader: eight-channel LED fader. A target on/off pattern is accepted
// through a valid/ready handshake, then each channel's 8-bit level ramps by
// STEP per ramp tick toward 0 or 255. Each LED is driven by a registered PWM
// comparison of its duty against a free-running 8-bit counter.
// Optional feature: define LED_GAMMA_EN to map level to duty as
// (level*level)>>8. When it is undefined the mapping is linear (duty = level).
module led_pwm_fader #(
  parameter int unsigned RAMP_DIV = 46875,
  parameter int unsigned STEP     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pat_in,
  input  logic       pat_valid,
  output logic       pat_ready,
  output logic       busy,
  output logic       LED0,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4,
  output logic       LED5,
  output logic       LED6,
  output logic       LED7
);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  localparam logic [23:0] PRESC_LAST = 24'(RAMP_DIV - 1);
  localparam logic [8:0]  STEP_W     = 9'(STEP);

  state_t      state;
  state_t      state_next;
  logic [7:0]  target;
  logic [7:0]  level      [8];
  logic [7:0]  level_next [8];
  logic [7:0]  duty       [8];
  logic [7:0]  pwm_cnt;
  logic [23:0] presc;
  logic [7:0]  led;
  logic        tick;
  logic        accept;
  logic        settled;

  assign tick      = (presc == PRESC_LAST);
  // Gated by rst_n so both flags read 0 for the whole time reset is held,
  // including the cycle before the synchronous reset edge.
  assign pat_ready = (state == IDLE) && rst_n;
  assign busy      = (state == RAMP) && rst_n;
  assign accept    = pat_valid && pat_ready;

  assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = led;

  // Free-running PWM counter and ramp prescaler, active in every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      presc   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      presc   <= tick ? '0 : presc + 24'd1;
    end
  end

  // All channels settled when every level sits at its target rail.
  always_comb begin
    settled = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (level[i] != {8{target[i]}}) begin
        settled = 1'b0;
      end
    end
  end

  // Saturating step of each level toward its target on a ramp tick.
  always_comb begin
    logic [8:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      level_next[i] = level[i];
      if (state == RAMP && tick) begin
        if (target[i]) begin
          sum           = {1'b0, level[i]} + STEP_W;
          level_next[i] = sum[8] ? 8'hFF : sum[7:0];
        end else if ({1'b0, level[i]} < STEP_W) begin
          level_next[i] = '0;
        end else begin
          level_next[i] = level[i] - STEP_W[7:0];
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept moves to RAMP, settled levels return to IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept)  state_next = RAMP;
      RAMP: if (settled) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Target capture on handshake and level update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        level[i] <= '0;
      end
    end else begin
      if (accept) begin
        target <= pat_in;
      end
      for (int unsigned i = 0; i < 8; i++) begin
        level[i] <= level_next[i];
      end
    end
  end

  // Level-to-duty mapping.
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
`ifdef LED_GAMMA_EN
      duty[i] = 8'((16'(level[i]) * 16'(level[i])) >> 8);
`else
      duty[i] = level[i];
`endif
    end
  end

  // Registered PWM compare; one clock of latency from the counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        led[i] <= (duty[i] > pwm_cnt);
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed self-checking bench for led_pwm_fader (RAMP_DIV=4, STEP=64).
module tb_led_pwm_fader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pat_in = '0;
  logic       pat_valid = 1'b0;
  logic       pat_ready;
  logic       busy;
  logic       LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7;
  logic [7:0] leds;
  logic [7:0] bcnt;

  int checks = 0;
  int errors = 0;

  assign leds = {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0};

  led_pwm_fader #(.RAMP_DIV(4), .STEP(64)) dut (
    .clk(clk), .rst_n(rst_n), .pat_in(pat_in), .pat_valid(pat_valid),
    .pat_ready(pat_ready), .busy(busy),
    .LED0(LED0), .LED1(LED1), .LED2(LED2), .LED3(LED3),
    .LED4(LED4), .LED5(LED5), .LED6(LED6), .LED7(LED7)
  );

  always #5 clk = ~clk;

  // Reference PWM counter.
  always @(posedge clk) begin
    if (!rst_n) bcnt <= '0;
    else        bcnt <= bcnt + 8'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] duty_of(input logic [7:0] l);
`ifdef LED_GAMMA_EN
    return 8'((16'(l) * 16'(l)) >> 8);
`else
    return l;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    ok = !busy;
  endtask

  task automatic load(input logic [7:0] p);
    pat_valid = 1'b1;
    pat_in = p;
    step();
    pat_valid = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    pat_valid = 1'b0;
    repeat (3) step();
    checks++;
    if (pat_ready !== 1'b0) begin errors++; $display("FAIL reset_pat_ready got %b want 0", pat_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (leds !== 8'h00) begin errors++; $display("FAIL reset_leds got %h want 00", leds); end
    bad = 0;
    for (int i = 0; i < 8; i++) if (dut.level[i] !== 8'd0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_levels nonzero_count got %0d want 0", bad); end
  endtask

  task automatic test_ramp_up();
    logic [7:0] exp_seq [4];
    logic [7:0] prev, lv_prev, cnt_prev;
    int idx, cyc, last, led_bad, hi;
    bit ok;
    exp_seq[0] = 8'd64; exp_seq[1] = 8'd128; exp_seq[2] = 8'd192; exp_seq[3] = 8'd255;
    // Release reset and present the first pattern in the same cycle.
    rst_n = 1'b1;
    pat_in = 8'h01;
    pat_valid = 1'b1;
    #1;
    checks++;
    if (pat_ready !== 1'b1) begin errors++; $display("FAIL first_edge_ready got %b want 1", pat_ready); end
    step();
    pat_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL up_busy_next got %b want 1", busy); end
    idx = 0; cyc = 0; last = 0; led_bad = 0;
    prev = dut.level[0];
    while (busy && cyc < 200) begin
      lv_prev = dut.level[0];
      cnt_prev = bcnt;
      step();
      cyc++;
      if (LED0 !== (duty_of(lv_prev) > cnt_prev) || leds[7:1] !== 7'd0) led_bad++;
      if (dut.level[0] !== prev) begin
        checks++;
        if (idx >= 4 || dut.level[0] !== exp_seq[idx % 4]) begin
          errors++;
          $display("FAIL up_level_step%0d got %0d want %0d", idx, dut.level[0], exp_seq[idx % 4]);
        end
        if (idx > 0) begin
          checks++;
          if (cyc - last != 4) begin errors++; $display("FAIL up_tick_spacing got %0d want 4", cyc - last); end
        end
        last = cyc;
        idx++;
        prev = dut.level[0];
      end
    end
    ok = !busy;
    checks++;
    if (!ok) begin errors++; $display("FAIL up_timeout busy got %b want 0", busy); end
    checks++;
    if (idx != 4) begin errors++; $display("FAIL up_step_count got %0d want 4", idx); end
    checks++;
    if (cyc - last != 1) begin errors++; $display("FAIL up_idle_delay got %0d want 1", cyc - last); end
    checks++;
    if (led_bad != 0) begin errors++; $display("FAIL up_led_model bad_cycles got %0d want 0", led_bad); end
    hi = 0; led_bad = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (LED0 === 1'b1) hi++;
      if (leds[7:1] !== 7'd0) led_bad++;
    end
    checks++;
`ifdef LED_GAMMA_EN
    if (hi != 254) begin errors++; $display("FAIL up_led0_duty got %0d want 254", hi); end
`else
    if (hi != 255) begin errors++; $display("FAIL up_led0_duty got %0d want 255", hi); end
`endif
    checks++;
    if (led_bad != 0) begin errors++; $display("FAIL up_led_others bad_cycles got %0d want 0", led_bad); end
  endtask

  task automatic test_ramp_down();
    logic [7:0] exp_seq [4];
    logic [7:0] prev;
    int idx, cyc, last, bad;
    bit ok;
    exp_seq[0] = 8'd191; exp_seq[1] = 8'd127; exp_seq[2] = 8'd63; exp_seq[3] = 8'd0;
    load(8'hFF);
    wait_idle(ok);
    bad = 0;
    for (int i = 0; i < 8; i++) if (dut.level[i] !== 8'd255) bad++;
    checks++;
    if (!ok || bad != 0) begin errors++; $display("FAIL ff_settle bad_levels got %0d want 0 (idle %b)", bad, ok); end
    load(8'h00);
    idx = 0; cyc = 0; last = 0; bad = 0;
    prev = dut.level[0];
    while (busy && cyc < 200) begin
      step();
      cyc++;
      for (int i = 1; i < 8; i++) if (dut.level[i] !== dut.level[0]) bad++;
      if (dut.level[0] !== prev) begin
        checks++;
        if (idx >= 4 || dut.level[0] !== exp_seq[idx % 4]) begin
          errors++;
          $display("FAIL down_level_step%0d got %0d want %0d", idx, dut.level[0], exp_seq[idx % 4]);
        end
        last = cyc;
        idx++;
        prev = dut.level[0];
      end
    end
    checks++;
    if (busy !== 1'b0 || idx != 4) begin errors++; $display("FAIL down_steps got %0d want 4 (busy %b)", idx, busy); end
    checks++;
    if (cyc - last != 1) begin errors++; $display("FAIL down_idle_delay got %0d want 1", cyc - last); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL down_channels_equal bad got %0d want 0", bad); end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (leds !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL down_leds_off bad_cycles got %0d want 0", bad); end
  endtask

  task automatic test_hold_valid();
    int k, bad;
    bit ok;
    pat_valid = 1'b1;
    pat_in = 8'h0F;
    step();
    checks++;
    if (busy !== 1'b1 || dut.target !== 8'h0F) begin
      errors++; $display("FAIL hold_first_accept target got %h want 0f (busy %b)", dut.target, busy);
    end
    k = 0; bad = 0;
    while (busy && k < 100) begin
      pat_in = 8'h30 + 8'(k);
      step();
      k++;
      if (dut.target !== 8'h0F) bad++;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL hold_timeout busy got %b want 0", busy); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_ignored target_changes got %0d want 0", bad); end
    checks++;
    if (pat_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_idle got %b want 1", pat_ready); end
    pat_in = 8'hC3;
    step();
    checks++;
    if (busy !== 1'b1 || dut.target !== 8'hC3) begin
      errors++; $display("FAIL hold_second_accept target got %h want c3 (busy %b)", dut.target, busy);
    end
    pat_valid = 1'b0;
    wait_idle(ok);
    bad = 0;
    for (int i = 0; i < 8; i++) if (dut.level[i] !== ((8'hC3 >> i) & 8'd1 ? 8'd255 : 8'd0)) bad++;
    checks++;
    if (!ok || bad != 0) begin errors++; $display("FAIL hold_settle_c3 bad got %0d want 0 (idle %b)", bad, ok); end
  endtask

  task automatic test_reset_mid_ramp();
    int n, bad;
    load(8'h3C);
    n = 0;
    while (dut.level[2] !== 8'd128 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (dut.level[2] !== 8'd128 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_reach128 got %0d want 128 (busy %b)", dut.level[2], busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pat_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_flags_in_reset ready/busy got %b%b want 00", pat_ready, busy);
    end
    step();
    bad = 0;
    for (int i = 0; i < 8; i++) if (dut.level[i] !== 8'd0) bad++;
    checks++;
    if (bad != 0 || leds !== 8'h00) begin errors++; $display("FAIL mid_cleared levels_bad %0d leds %h want 0 00", bad, leds); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (pat_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after got %b want 1", pat_ready); end
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (busy !== 1'b0 || dut.level[2] !== 8'd0 || dut.level[0] !== 8'd0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mid_no_resume bad_cycles got %0d want 0", bad); end
  endtask

  task automatic test_same_pattern();
    logic [7:0] snap [8];
    int n, bad;
    bit ok;
    load(8'hA5);
    wait_idle(ok);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      snap[i] = dut.level[i];
      if (dut.level[i] !== ((8'hA5 >> i) & 8'd1 ? 8'd255 : 8'd0)) bad++;
    end
    checks++;
    if (!ok || bad != 0) begin errors++; $display("FAIL same_first_settle bad got %0d want 0 (idle %b)", bad, ok); end
    load(8'hA5);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL same_enter_ramp got %b want 1", busy); end
    n = 0;
    while (busy && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n != 1) begin errors++; $display("FAIL same_ramp_len got %0d want 1", n); end
    bad = 0;
    for (int i = 0; i < 8; i++) if (dut.level[i] !== snap[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL same_levels_kept changed got %0d want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_hold_valid();
    test_reset_mid_ramp();
    test_same_pattern();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
